// File: rtl/pipeline_pkg.sv
// Shared EX/MEM pipeline types and constants.
// ex_mem_entry_t shows the field layout at the default widths.
package pipeline_pkg;

    localparam int EX_MEM_DEPTH          = 2;
    localparam int EX_MEM_DATA_WIDTH     = 32;
    localparam int EX_MEM_REG_ADDR_WIDTH = 5;

    typedef struct packed {
        logic [EX_MEM_DATA_WIDTH-1:0]     alu_result;
        logic [EX_MEM_DATA_WIDTH-1:0]     store_data;
        logic [EX_MEM_REG_ADDR_WIDTH-1:0] rd;
        logic                             reg_write;
        logic                             mem_read;
        logic                             mem_write;
    } ex_mem_entry_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pipe_fifo2.sv
// Generic two-entry FIFO with flush. Slot 0 is always the head.
// The entry type is a parameter.
module pipe_fifo2
    import pipeline_pkg::*;
#(
    parameter type entry_t = logic [7:0]
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  entry_t     din,
    output entry_t     head,
    output logic [1:0] count
);

    localparam logic [1:0] FULL = 2'(EX_MEM_DEPTH);

    entry_t     slot0;
    entry_t     slot1;
    logic [1:0] cnt;
    logic       do_push;
    logic       do_pop;

    assign do_push = push && (cnt < FULL);
    assign do_pop  = pop && (cnt != 2'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt   <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            cnt <= 2'd0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10: begin
                    if (cnt == 2'd0) slot0 <= din;
                    else             slot1 <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    cnt   <= cnt - 2'd1;
                end
                // A push is only possible here with one entry held, so the new entry becomes the head.
                2'b11: slot0 <= din;
                default: ;
            endcase
        end
    end

    assign head  = (cnt != 2'd0) ? slot0 : '0;
    assign count = cnt;

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX/MEM pipeline stage that holds two entries. It drives forwarding from the head entry
// and counts cycles of MEM back-pressure.
module ex_mem_skid_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ex_valid,
    output logic                      ex_ready,
    input  logic [DATA_WIDTH-1:0]     ex_alu_result,
    input  logic [DATA_WIDTH-1:0]     ex_store_data,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_reg_write,
    input  logic                      ex_mem_read,
    input  logic                      ex_mem_write,
    input  logic                      flush,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [DATA_WIDTH-1:0]     mem_alu_result,
    output logic [DATA_WIDTH-1:0]     mem_store_data,
    output logic [REG_ADDR_WIDTH-1:0] mem_rd,
    output logic                      mem_reg_write,
    output logic                      mem_mem_read,
    output logic                      mem_mem_write,
    output logic                      fwd_valid,
    output logic [REG_ADDR_WIDTH-1:0] fwd_rd,
    output logic [DATA_WIDTH-1:0]     fwd_data,
    output logic [1:0]                occupancy,
    output logic [15:0]               stall_count
);

    localparam logic [1:0] FULL = 2'(EX_MEM_DEPTH);

    // This type has the same layout as ex_mem_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [DATA_WIDTH-1:0]     alu_result;
        logic [DATA_WIDTH-1:0]     store_data;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_write;
        logic                      mem_read;
        logic                      mem_write;
    } stage_entry_t;

    stage_entry_t din;
    stage_entry_t head;
    logic         push;
    logic         pop;

    assign ex_ready  = (occupancy < FULL);
    assign mem_valid = (occupancy != 2'd0);
    assign push      = ex_valid && ex_ready && !flush;
    assign pop       = mem_valid && mem_ready && !flush;

    assign din = '{
        alu_result: ex_alu_result,
        store_data: ex_store_data,
        rd:         ex_rd,
        reg_write:  ex_reg_write,
        mem_read:   ex_mem_read,
        mem_write:  ex_mem_write
    };

    pipe_fifo2 #(
        .entry_t(stage_entry_t)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .flush(flush),
        .din  (din),
        .head (head),
        .count(occupancy)
    );

    assign mem_alu_result = head.alu_result;
    assign mem_store_data = head.store_data;
    assign mem_rd         = head.rd;
    assign mem_reg_write  = head.reg_write;
    assign mem_mem_read   = head.mem_read;
    assign mem_mem_write  = head.mem_write;

    assign fwd_valid = mem_valid && head.reg_write && (head.rd != '0);
    assign fwd_rd    = head.rd;
    assign fwd_data  = head.alu_result;

    // Flush leaves the stall counter running. Only reset clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_count <= 16'd0;
        end else if (mem_valid && !mem_ready) begin
            stall_count <= sat_inc16(stall_count);
        end
    end

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Bench for ex_mem_skid_stage: directed scenarios followed by random traffic,
// compared against a queue model.
module tb_ex_mem_skid_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        flush;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_store_data;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        mem_mem_read;
    logic        mem_mem_write;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    ex_mem_skid_stage dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .flush         (flush),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_alu_result(mem_alu_result),
        .mem_store_data(mem_store_data),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_mem_read  (mem_mem_read),
        .mem_mem_write (mem_mem_write),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data),
        .occupancy     (occupancy),
        .stall_count   (stall_count)
    );

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } ent_t;

    ent_t        q[$];
    logic [15:0] m_stall;
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        ent_t h;
        h = (q.size() != 0) ? q[0] : '0;
        check("ex_ready",       ex_ready,       q.size() < 2);
        check("mem_valid",      mem_valid,      q.size() != 0);
        check("occupancy",      occupancy,      q.size());
        check("mem_alu_result", mem_alu_result, h.alu);
        check("mem_store_data", mem_store_data, h.sd);
        check("mem_rd",         mem_rd,         h.rd);
        check("mem_reg_write",  mem_reg_write,  h.rw);
        check("mem_mem_read",   mem_mem_read,   h.mr);
        check("mem_mem_write",  mem_mem_write,  h.mw);
        check("fwd_valid",      fwd_valid,      (q.size() != 0) && h.rw && (h.rd != 5'd0));
        check("fwd_rd",         fwd_rd,         h.rd);
        check("fwd_data",       fwd_data,       h.alu);
        check("stall_count",    stall_count,    m_stall);
    endtask

    // Update the model from the current inputs, then clock once and compare.
    task automatic step();
        ent_t e;
        bit   can_push;
        bit   can_pop;
        e = {ex_alu_result, ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write};
        if (!reset) begin
            q.delete();
            m_stall = 16'd0;
        end else begin
            if (q.size() != 0 && !mem_ready && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (flush) begin
                q.delete();
            end else begin
                can_push = ex_valid && (q.size() < 2);
                can_pop  = (q.size() != 0) && mem_ready;
                if (can_pop)  void'(q.pop_front());
                if (can_push) q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                         input logic rw, input logic mrdy, input logic fl);
        ex_valid      = v;
        ex_alu_result = alu;
        ex_store_data = ~alu;
        ex_rd         = rd;
        ex_reg_write  = rw;
        ex_mem_read   = alu[0];
        ex_mem_write  = alu[1];
        mem_ready     = mrdy;
        flush         = fl;
    endtask

    initial begin
        m_stall = 16'd0;
        reset   = 1'b0;
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check("rst_occupancy", occupancy, 2'd0);
        check("rst_ex_ready", ex_ready, 1'b1);
        reset = 1'b1;

        // A single push appears on the mem_* outputs one cycle later.
        drive(1'b1, 32'h0000_00FF, 5'd5, 1'b1, 1'b1, 1'b0);
        step();
        check("p1_mem_valid", mem_valid, 1'b1);
        check("p1_alu", mem_alu_result, 32'hFF);
        check("p1_fwd_valid", fwd_valid, 1'b1);
        check("p1_fwd_rd", fwd_rd, 5'd5);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        check("p1_drained", occupancy, 2'd0);

        // With MEM stalled, three back-to-back pushes: the third is refused.
        begin
            logic [15:0] s0;
            s0 = stall_count;
            drive(1'b1, 32'h1111_0001, 5'd1, 1'b1, 1'b0, 1'b0);
            step();
            check("bp_ready1", ex_ready, 1'b1);
            drive(1'b1, 32'h2222_0002, 5'd2, 1'b1, 1'b0, 1'b0);
            step();
            check("bp_ready2", ex_ready, 1'b0);
            check("bp_occ2", occupancy, 2'd2);
            drive(1'b1, 32'h3333_0003, 5'd3, 1'b1, 1'b0, 1'b0);
            step();
            check("bp_occ3", occupancy, 2'd2);
            check("bp_head", mem_alu_result, 32'h1111_0001);
            check("bp_stall", stall_count, s0 + 16'd2);
            drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            step();
            check("bp_second", mem_alu_result, 32'h2222_0002);
            step();
            check("bp_empty", mem_valid, 1'b0);
        end

        // With one entry held, a push and a pop in the same cycle.
        drive(1'b1, 32'hAAAA_0000, 5'd7, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hBBBB_0000, 5'd8, 1'b1, 1'b1, 1'b0);
        step();
        check("sim_occ", occupancy, 2'd1);
        check("sim_head", mem_alu_result, 32'hBBBB_0000);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        check("sim_drained", occupancy, 2'd0);

        // Flush with a full stage and a push in the same cycle.
        drive(1'b1, 32'hC0DE_0001, 5'd9, 1'b1, 1'b0, 1'b0);
        step();
        step();
        drive(1'b1, 32'hC0DE_0003, 5'd9, 1'b1, 1'b1, 1'b1);
        step();
        check("fl_occ", occupancy, 2'd0);
        check("fl_valid", mem_valid, 1'b0);
        check("fl_zero_data", mem_alu_result, 32'd0);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        check("fl_still_empty", occupancy, 2'd0);

        // An entry with rd=0 must not forward.
        drive(1'b1, 32'h1234_5678, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("rd0_valid", mem_valid, 1'b1);
        check("rd0_fwd", fwd_valid, 1'b0);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        step();

        // Assert reset with the stage full and stall_count at 7.
        reset = 1'b0;
        step();
        reset = 1'b1;
        drive(1'b1, 32'h5555_0001, 5'd4, 1'b1, 1'b0, 1'b0);
        step();
        step();
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && m_stall < 16'd7; i++) step();
        check("rs_stall7", stall_count, 16'd7);
        check("rs_occ2", occupancy, 2'd2);
        reset = 1'b0;
        step();
        check("rs_occ", occupancy, 2'd0);
        check("rs_stall", stall_count, 16'd0);
        check("rs_valid", mem_valid, 1'b0);
        check("rs_fwd", fwd_valid, 1'b0);
        check("rs_ready", ex_ready, 1'b1);
        reset = 1'b1;
        step();

        for (int n = 0; n < 1500; n++) begin
            reset         = ($urandom_range(0, 99) != 0);
            flush         = ($urandom_range(0, 9) == 0);
            ex_valid      = $urandom_range(0, 1);
            mem_ready     = ($urandom_range(0, 2) != 0);
            ex_alu_result = $urandom;
            ex_store_data = $urandom;
            ex_rd         = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ex_reg_write  = $urandom_range(0, 1);
            ex_mem_read   = $urandom_range(0, 1);
            ex_mem_write  = $urandom_range(0, 1);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
